// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the loadable instruction memory.
package imem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

endpackage

// File: rtl/imem_sram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module imem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: LOAD/RUN FSM, fetch fault detection, optional
// XOR load checksum (enabled by defining IMEM_CSUM_EN).
module imem_loadable
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          reload,
  output logic [AW:0]   ld_count,
  output logic          boot_done,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic          if_fault
`ifdef IMEM_CSUM_EN
  ,
  output logic [31:0]   ld_csum
`endif
);

  state_t        state_q;
  logic          ld_ready_q;
  logic [AW:0]   ld_count_q;
  logic [AW:0]   ld_count_d;
  logic          if_valid_q;
  logic          fault_q;
  logic          fault_d;
  logic          ld_hs;
  logic          ld_term;
  logic          fetch;
  logic          do_reload;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rdata;

  assign ld_hs      = ld_valid && ld_ready_q;
  assign ld_count_d = ld_count_q + 1'b1;
  assign ld_term    = ld_hs && (ld_last || (ld_count_d == (AW+1)'(DEPTH)));
  assign do_reload  = (state_q == S_RUN) && reload;
  assign fetch      = (state_q == S_RUN) && if_req && !reload;
  assign rd_idx     = if_addr[AW+1:2];

  always_comb begin
    fault_d = 1'b0;
    if ((if_addr[1:0] != 2'b00) || (if_addr[31:AW+2] != '0) ||
        ({1'b0, rd_idx} >= ld_count_q)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      ld_ready_q <= 1'b0;
      ld_count_q <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if_valid_q <= fetch;
      if (fetch) begin
        fault_q <= fault_d;
      end
      case (state_q)
        S_LOAD: begin
          if (ld_hs) begin
            ld_count_q <= ld_count_d;
          end
          if (ld_term) begin
            state_q    <= S_RUN;
            ld_ready_q <= 1'b0;
          end else begin
            ld_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (reload) begin
            state_q    <= S_LOAD;
            ld_count_q <= '0;
            ld_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_LOAD;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_CSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst || do_reload) begin
      csum_q <= '0;
    end else if (ld_hs) begin
      csum_q <= csum_q ^ ld_data;
    end
  end

  assign ld_csum = csum_q;
`endif

  imem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ld_hs),
    .waddr_i (ld_count_q[AW-1:0]),
    .wdata_i (ld_data),
    .re_i    (fetch),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  // Fault flag and read data are captured together, so the NOP substitution
  // also holds with if_instr between responses.
  assign if_instr  = fault_q ? NOP_INSTR : rdata;
  assign if_fault  = if_valid_q && fault_q;
  assign if_valid  = if_valid_q;
  assign ld_ready  = ld_ready_q;
  assign ld_count  = ld_count_q;
  assign boot_done = (state_q == S_RUN);

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable (DEPTH=4); checks ld_csum when IMEM_CSUM_EN is defined.
module tb_imem_loadable;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_ready, ld_last, reload, boot_done;
  logic        if_req, if_valid, if_fault;
  logic [31:0] ld_data, if_addr, if_instr;
  logic [2:0]  ld_count;
`ifdef IMEM_CSUM_EN
  logic [31:0] ld_csum;
`endif

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [31:0] mem_m [DEPTH];
  int unsigned cnt_m;
  bit          run_m;
  logic [31:0] csum_m;

  always #5 clk = ~clk;

  imem_loadable #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .reload    (reload),
    .ld_count  (ld_count),
    .boot_done (boot_done),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_fault  (if_fault)
`ifdef IMEM_CSUM_EN
    ,
    .ld_csum   (ld_csum)
`endif
  );

  // Response monitor: every if_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got instr=%h fault=%b, required no response", if_instr, if_fault);
      end else begin
        mon_e = exp_q.pop_front();
        if ({if_fault, if_instr} !== mon_e) begin
          errors++;
          $display("FAIL fetch_resp: got fault=%b instr=%h, required fault=%b instr=%h",
                   if_fault, if_instr, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cnt_m  = 0;
    run_m  = 1'b0;
    csum_m = '0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    for (int i = 0; i < 8; i++) begin
      if (ld_ready === 1'b1) begin
        mem_m[cnt_m] = d;
        cnt_m++;
        csum_m ^= d;
        if (last || cnt_m == DEPTH) run_m = 1'b1;
        cyc();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        return;
      end
      cyc();
    end
    checks++;
    errors++;
    $display("FAIL load_timeout: got ld_ready=%b for 8 cycles, required 1", ld_ready);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic flt;
    flt = (a[1:0] != 2'b00) || (a[31:4] != '0) || (int'(a[3:2]) >= cnt_m);
    if_req  = 1'b1;
    if_addr = a;
    if (run_m) exp_q.push_back(flt ? {1'b1, NOP} : {1'b0, mem_m[a[3:2]]});
    cyc();
    if_req = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    if (run_m) model_reset();
    cyc();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    cyc();
    cyc();
    checks++;
    if ({ld_ready, ld_count, boot_done, if_valid, if_fault} !== 7'b0 || if_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b count=%0d boot=%b valid=%b fault=%b instr=%h, required all zero",
               ld_ready, ld_count, boot_done, if_valid, if_fault, if_instr);
    end
`ifdef IMEM_CSUM_EN
    checks++;
    if (ld_csum !== 32'h0) begin
      errors++;
      $display("FAIL reset_csum: got %h, required 0", ld_csum);
    end
`endif
    rst = 1'b1;
    cyc();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", ld_ready);
    end
  endtask

  task automatic test_single_load();
    load_word(32'h0060_0093, 1'b1);
    checks++;
    if (ld_count !== 3'd1 || boot_done !== 1'b1 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_load: got count=%0d boot=%b ready=%b, required 1 1 0", ld_count, boot_done, ld_ready);
    end
    fetch(32'h0);
    cyc();
    fetch(32'h4);
    fetch(32'h2);
    cyc();
    cyc();
    checks++;
    if (if_instr !== NOP) begin
      errors++;
      $display("FAIL instr_hold: got %h, required %h", if_instr, NOP);
    end
  endtask

  task automatic test_full();
    do_reload();
    checks++;
    if (ld_count !== 3'd0 || ld_ready !== 1'b1 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL reload_state: got count=%0d ready=%b boot=%b, required 0 1 0", ld_count, ld_ready, boot_done);
    end
    load_word(32'h1111_0001, 1'b0);
    load_word(32'hA5A5_5A5A, 1'b0);
    load_word(32'h0000_00FF, 1'b0);
    load_word(32'hFEDC_BA98, 1'b0);
    checks++;
    if (ld_count !== 3'd4 || boot_done !== 1'b1 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load: got count=%0d boot=%b ready=%b, required 4 1 0", ld_count, boot_done, ld_ready);
    end
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    cyc();
    ld_valid = 1'b0;
    checks++;
    if (ld_count !== 3'd4 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL extra_word_ignored: got count=%0d ready=%b, required 4 0", ld_count, ld_ready);
    end
    fetch(32'hC);
    fetch(32'h8);
    fetch(32'h4);
    fetch(32'h0);
    fetch(32'h10);
    fetch(32'h8000_0000);
    fetch(32'h1);
    cyc();
    cyc();
  endtask

  task automatic test_reset_midload();
    do_reload();
    load_word(32'h0BAD_0001, 1'b0);
    load_word(32'h0BAD_0002, 1'b0);
    rst = 1'b0;
    model_reset();
    cyc();
    checks++;
    if (ld_count !== 3'd0 || ld_ready !== 1'b0 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: got count=%0d ready=%b boot=%b, required 0 0 0", ld_count, ld_ready, boot_done);
    end
    rst = 1'b1;
    cyc();
    load_word(32'h0020_0113, 1'b1);
    fetch(32'h4);
    fetch(32'h0);
    cyc();
    cyc();
  endtask

  task automatic test_reload_fetch();
    reload  = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h0;
    model_reset();
    cyc();
    reload = 1'b0;
    if_req = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || ld_count !== 3'd0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_vs_fetch: got valid=%b count=%0d ready=%b, required 0 0 1", if_valid, ld_count, ld_ready);
    end
    cyc();
  endtask

  task automatic test_final_hs_fetch();
    if_req  = 1'b1;
    if_addr = 32'h0;
    load_word(32'h0030_0193, 1'b1);
    if_req = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL final_hs_fetch: got valid=%b boot=%b, required 0 1", if_valid, boot_done);
    end
    cyc();
    fetch(32'h0);
    cyc();
  endtask

  task automatic test_csum();
`ifdef IMEM_CSUM_EN
    do_reload();
    checks++;
    if (ld_csum !== 32'h0) begin
      errors++;
      $display("FAIL csum_reload: got %h, required 0", ld_csum);
    end
    load_word(32'h0060_0093, 1'b0);
    load_word(32'h4062_8233, 1'b1);
    checks++;
    if (ld_csum !== 32'h4002_82A0 || ld_csum !== csum_m) begin
      errors++;
      $display("FAIL csum_value: got %h, required %h", ld_csum, 32'h4002_82A0);
    end
`endif
  endtask

  initial begin
    rst      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    test_reset();
    test_single_load();
    test_full();
    test_reset_midload();
    test_reload_fetch();
    test_final_hs_fetch();
    test_csum();
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d outstanding expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the RISC-V core. It replaces the hard-initialised fetch ROM. After reset it accepts a program over a valid/ready load port, then serves registered, one-cycle-latency fetches to the IF stage. Misaligned and out-of-range fetches are flagged.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; power of two, ≥ 4.
- AW, $clog2(DEPTH): word-index width; derived, not overridden.
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets).
- ld_valid  in  1  load word offered.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- ld_data  in  32  instruction word to store.
- ld_last  in  1  qualifies the final word of the program.
- reload  in  1  single-cycle pulse in RUN; re-enters LOAD.
- ld_count  out  AW+1  words loaded so far.
- boot_done  out  1  high in RUN.
- if_req  in  1  fetch request.
- if_addr  in  32  byte address.
- if_valid  out  1  fetch response valid.
- if_instr  out  32  fetched instruction, or NOP on fault.
- if_fault  out  1  response is a fault.
- ld_csum  out  32  XOR checksum of loaded words; present only with IMEM_CSUM_EN.

## Operation
- FSM states: LOAD (reset state) and RUN.
- LOAD: ld_ready=1. Each handshake writes ld_data to mem[ld_count] and increments ld_count.
- LOAD→RUN happens on a handshake with ld_last=1, or on a handshake that makes ld_count==DEPTH (full).
- Load data offered while ld_count==DEPTH is impossible, because the FSM has already left LOAD.
- RUN: ld_ready=0 and ld_valid is ignored.
- reload=1 in RUN: go to LOAD and clear ld_count to 0. ld_csum also clears when present. Memory contents are retained.
- reload in LOAD is ignored.
- Fetch is serviced only in RUN. if_req in LOAD produces no response.
- Word index is if_addr[AW+1:2].
- Fault conditions, any one of:
  - if_addr[1:0]!=0
  - if_addr[31:AW+2]!=0
  - word index ≥ ld_count
- On fault: if_fault=1 and if_instr=32'h0000_0013 (NOP).
- No fault: if_instr=mem[index] and if_fault=0.
- Simultaneous events:
  - reload and if_req in the same cycle: reload wins and the fetch is dropped (if_valid=0 next cycle).
  - Final load handshake and if_req in the same cycle: the fetch is dropped.
- Reset mid-operation (any state): go to LOAD and clear all counters/outputs. Any in-flight fetch response is squashed. Memory contents are not cleared.

## Timing
- Reset values: ld_ready=0 during reset, 1 from the first cycle after rst deasserts. ld_count=0, boot_done=0, if_valid=0, if_instr=0, if_fault=0, ld_csum=0.
- Load throughput: one word per cycle.
- boot_done rises the cycle after the terminating handshake.
- Fetch latency: exactly 1 cycle. if_req at edge N gives if_valid/if_instr/if_fault valid after edge N+1.
- Fetch throughput: back-to-back, one per cycle, no backpressure.
- if_valid is a single-cycle pulse per request. if_instr holds its last value when if_valid=0.
- Read-during-write cannot occur, since writes happen only in LOAD and reads only in RUN.

## Configuration
- IMEM_CSUM_EN defined: port ld_csum exists. It is reset/reload to 0 and becomes ld_csum ^ ld_data on each accepted load word, updated the cycle after the handshake.
- IMEM_CSUM_EN undefined: port and register are absent. All other behaviour is identical.

## Structure
- Package imem_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - state typedef {S_LOAD, S_RUN}
  - DEFAULT_DEPTH = 1024
- Sub-module imem_sram: simple dual-port synchronous RAM, parameters DEPTH/AW, one write port and one registered read port. The FSM, fault logic and checksum stay in imem_loadable.

## Test plan
- Load 32'h00600093 with ld_last=1 → ld_count=1, boot_done=1 next cycle. Fetch if_addr=0 → if_valid=1, if_instr=32'h00600093, if_fault=0 one cycle later.
- With ld_count=1, fetch if_addr=4 and then if_addr=2 back-to-back → two consecutive responses, each if_fault=1 with if_instr=32'h00000013.
- DEPTH=4: load 4 words with ld_last=0 → RUN after the 4th, ld_ready=0. A 5th ld_valid is ignored and ld_count stays 4.
- Reset mid-load after 2 words → ld_count=0 and state LOAD. Reload 1 word; a fetch of addr 4 faults.
- RUN with reload and if_req in the same cycle → no if_valid, ld_count=0, ld_ready=1 next cycle.
- IMEM_CSUM_EN: load 32'h00600093 then 32'h40628233 → ld_csum=32'h400282A0.
